// File: rtl/ram_pkg.sv
// ram_pkg: shared state encoding and default geometry for ram_banked
package ram_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_BANK_AW = 6;
  localparam int DEF_SEL_W = 3;
endpackage

// File: rtl/ram_bank.sv
// ram_bank: one bank, synchronous write, registered read-before-write (ports: clk, we, addr, wdata, rdata)
module ram_bank #(
  parameter int WIDTH = 16,
  parameter int BANK_AW = 6
) (
  input  logic               clk,
  input  logic               we,
  input  logic [BANK_AW-1:0] addr,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata
);
  logic [WIDTH-1:0] mem [2**BANK_AW];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/ram_banked.sv
// ram_banked: banked RAM with zero-fill sequencer and valid/busy status (ports: clk, rst_n, in, address, load, clr, out, out_valid, busy; RAM_BANKED_WRFWD_EN forwards write data on same-cycle read)
module ram_banked import ram_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BANK_AW = DEF_BANK_AW,
  parameter int SEL_W = DEF_SEL_W,
  localparam int AW = SEL_W + BANK_AW,
  localparam int DEPTH = 2**AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [AW-1:0]    address,
  input  logic             load,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy
);
  state_t state, state_nx;
  logic [AW-1:0] cnt;
  logic ready, wr;
  logic [SEL_W-1:0] sel, sel_q;
  logic [BANK_AW-1:0] baddr;
  logic [WIDTH-1:0] wdata, hold, rd_mux;
  logic [WIDTH-1:0] rdata [2**SEL_W];
  assign ready = state == READY;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= ready ? '0 : cnt + 1'b1;
    end
  end
  always_comb state_nx = ready ? (clr ? CLEAR : READY) : (cnt == AW'(DEPTH-1) ? READY : CLEAR);
  // While clearing, the counter drives the bank port with zero data
  always_comb begin
    wr = ready ? load : 1'b1;
    sel = ready ? address[AW-1:BANK_AW] : cnt[AW-1:BANK_AW];
    baddr = ready ? address[BANK_AW-1:0] : cnt[BANK_AW-1:0];
    wdata = ready ? in : '0;
  end
  for (genvar b = 0; b < 2**SEL_W; b++) begin : g_bank
    ram_bank #(.WIDTH(WIDTH), .BANK_AW(BANK_AW)) u_bank (
      .clk(clk),
      .we(wr && sel == SEL_W'(b)),
      .addr(baddr),
      .wdata(wdata),
      .rdata(rdata[b])
    );
  end
  // hold captures the last visible result so out stays put during a fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b1;
      out_valid <= 1'b0;
      hold <= '0;
      sel_q <= '0;
    end else begin
      busy <= !ready;
      out_valid <= ready && !clr;
      sel_q <= address[AW-1:BANK_AW];
      if (out_valid) hold <= out;
    end
  end
`ifdef RAM_BANKED_WRFWD_EN
  logic fwd_q;
  logic [WIDTH-1:0] fwd_d;
  // One address port: every READY write is a same-address read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q <= 1'b0;
      fwd_d <= '0;
    end else begin
      fwd_q <= ready && load;
      fwd_d <= in;
    end
  end
  assign rd_mux = fwd_q ? fwd_d : rdata[sel_q];
`else
  assign rd_mux = rdata[sel_q];
`endif
  assign out = out_valid ? rd_mux : hold;
endmodule

// File: tb/tb_ram_banked.sv
// tb_ram_banked: directed self-checking bench for ram_banked
module tb_ram_banked;
  logic clk, rst_n, load, clr, out_valid, busy;
  logic [15:0] in, out;
  logic [8:0] address;
  int n_cmp = 0;
  int n_bad = 0;
  int n, bad;
  logic [15:0] held;

  ram_banked dut (
    .clk(clk), .rst_n(rst_n), .in(in), .address(address), .load(load),
    .clr(clr), .out(out), .out_valid(out_valid), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d);
    address = a; in = d; load = 1; step(); load = 0;
  endtask

  task automatic rd(input string tag, input logic [8:0] a, input logic [15:0] exp);
    address = a; load = 0; step(); chk(tag, out, exp);
  endtask

  task automatic count_busy(input int clr_at, output int cnt);
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      clr = (i == clr_at);
      step();
      clr = 0;
      if (!busy) break;
      cnt++;
    end
  endtask

  initial begin
    rst_n = 0; load = 0; clr = 0; in = 0; address = 0;
    step(); step();
    chk("rst_busy", busy, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_out", out, 0);
    rst_n = 1;
    count_busy(-1, n);
    chk("fill_len", n, 512);
    chk("fill_valid", out_valid, 1);
    rd("rd0", 9'h000, 16'h0);
    rd("rd255", 9'h0FF, 16'h0);
    rd("rd511", 9'h1FF, 16'h0);
    wr(9'h040, 16'hBEEF);
    wr(9'h1C0, 16'h1234);
    rd("iso000", 9'h000, 16'h0);
    rd("iso040", 9'h040, 16'hBEEF);
    rd("iso1c0", 9'h1C0, 16'h1234);
    rd("iso1ff", 9'h1FF, 16'h0);
    wr(9'h0A5, 16'h1111);
    wr(9'h0A5, 16'h5A5A);
`ifdef RAM_BANKED_WRFWD_EN
    chk("rdw_out", out, 16'h5A5A);
`else
    chk("rdw_out", out, 16'h1111);
`endif
    rd("rdw_next", 9'h0A5, 16'h5A5A);
    wr(9'h100, 16'hFFFF);
`ifdef RAM_BANKED_WRFWD_EN
    held = 16'hFFFF;
`else
    held = 16'h0000;
`endif
    chk("pre_clr_out", out, held);
    address = 9'h100; clr = 1; step(); clr = 0;
    chk("clr_valid", out_valid, 0);
    chk("clr_hold", out, held);
    load = 1; in = 16'hABCD;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      step();
      if (!busy || out_valid || out !== held) bad++;
    end
    chk("clr_window", bad, 0);
    load = 0; step();
    chk("clr_done_busy", busy, 0);
    chk("clr_done_valid", out_valid, 1);
    chk("clr_rd100", out, 16'h0);
    rd("clr_rd040", 9'h040, 16'h0);
    rst_n = 0; step(); rst_n = 1;
    for (int i = 0; i < 200; i++) step();
    chk("mid_busy", busy, 1);
    rst_n = 0; step();
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_valid", out_valid, 0);
    rst_n = 1;
    count_busy(100, n);
    chk("refill_len", n, 512);
    chk("refill_valid", out_valid, 1);
    rd("refill_rd1c0", 9'h1C0, 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_banked.md
# ram_banked

Parametrised banked RAM, the next generation of the fixed-size ram64/ram512 hierarchy. The address is split into a bank select and an in-bank address. Each bank is written only when selected, and a single registered read port returns data one cycle after the address is presented. The block adds two things the fixed versions lack: a hardware zero-fill sequencer, run after reset and on request, and a valid/busy status pair. Register-file and data-memory users in the CPU datapath instantiate it in place of hand-built RAM trees.

## Interface
Parameters:
- WIDTH, 16, data word width in bits.
- BANK_AW, 6, in-bank address width; each bank holds 2^BANK_AW words.
- SEL_W, 3, bank-select width; 2^SEL_W banks.
- Derived (localparam): AW = SEL_W + BANK_AW; DEPTH = 2^AW.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in  in  WIDTH  write data.
- address  in  AW  word address. address[AW-1:BANK_AW] selects the bank; address[BANK_AW-1:0] is the in-bank address.
- load  in  1  write enable, sampled at the rising edge.
- clr  in  1  pulse to request a full zero-fill.
- out  out  WIDTH  registered read data.
- out_valid  out  1  out holds a read result for the address presented on the previous edge.
- busy  out  1  zero-fill in progress; loads are ignored.

## Operation
- States:
  - CLEAR: the sequencer writes 0 to every word.
  - READY: normal read/write.
- Reset (rst_n low): state=CLEAR, fill counter=0, out=0, out_valid=0, busy=1. Memory array is not reset; the fill initialises it.
- CLEAR, each cycle:
  - Writes 0 to word[counter] and increments the counter.
  - Bank select and in-bank address come from the counter, split the same way as address.
  - When counter=DEPTH-1, that word is written and the next state is READY.
  - CLEAR lasts exactly DEPTH cycles.
- READY, each edge:
  - If load=1, write in to word[address] in the selected bank only. All other banks are untouched.
  - Every edge performs a read of word[address]. out and out_valid=1 register at that edge.
- clr=1 while READY: next state CLEAR, counter=0. Any load in that same cycle is still performed, and is then overwritten by the fill.
- clr while CLEAR: ignored; the fill does not restart.
- load while CLEAR: ignored; no write occurs.
- During CLEAR: out holds its last value and out_valid=0.
- rst_n asserted mid-fill: state returns to CLEAR with counter=0, and the full fill reruns after release.
- Address wrap: none. address covers exactly DEPTH words, and every value is legal.
- Read-during-write to the same address: behaviour set by the macro under Configuration.

## Timing
- Read latency: 1 cycle. Address A is sampled at edge N, and out=word[A] is visible after edge N.
- Write latency: 0 cycles. The word is updated at the edge where load=1.
- out_valid:
  - Rises at the first edge in READY, i.e. the edge after the last fill write.
  - Falls at the edge that enters CLEAR.
- busy is a registered copy of (state==CLEAR). It falls in the same cycle out_valid rises.
- Fill cycles after rst_n release: DEPTH (512 with defaults).

## Configuration
- RAM_BANKED_WRFWD_EN defined: a same-cycle read and write to the same address returns the new data (in) on out.
- RAM_BANKED_WRFWD_EN undefined: out returns the old stored word (read-before-write).
- Both modes: reads of other addresses are unaffected, and the stored result is identical.

## Structure
- Package ram_pkg holds:
  - the state enum {CLEAR, READY};
  - default width constants (WIDTH=16, BANK_AW=6, SEL_W=3).
- One sub-module, ram_bank:
  - Parameters WIDTH and BANK_AW.
  - Ports: write enable, in-bank address, write data, registered read output.
  - Generated 2^SEL_W times.
- Top level contains:
  - the fill FSM and counter;
  - per-bank write-enable decode;
  - the output mux, selected by a registered copy of the bank select;
  - the optional forwarding path.

## Test plan
- Reset fill: deassert rst_n and count cycles. Required: busy=1 for exactly 512 cycles, then out_valid=1, and reads of addresses 0, 255 and 511 return 0.
- Bank isolation:
  - Write 0xBEEF to 0x040 and 0x1234 to 0x1C0.
  - Read 0x000, 0x040, 0x1C0, 0x1FF. Required: 0, 0xBEEF, 0x1234, 0.
- Read-during-write: load=1, address=0x0A5, in=0x5A5A, over old data 0x1111. Required: out=0x5A5A with the macro defined, 0x1111 without; a read on the next cycle returns 0x5A5A in both modes.
- clr mid-operation:
  - Write 0xFFFF to 0x100, then pulse clr.
  - Required: out_valid=0 and busy=1 for 512 cycles, load ignored throughout, and a read of 0x100 afterwards returns 0.
- Reset mid-fill: assert rst_n low at fill cycle 200. Required: after release, busy stays high for a full 512 cycles again, and a clr pulse during CLEAR does not extend it.
